// File: rtl/ram_datapath_pkg.sv
// Shared opcodes, ALU function codes, FSM encoding and control-word layout
// for the ram_datapath control unit.
package ram_datapath_pkg;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_BR   = 11'b11010110000;
    localparam logic [5:0]  OP_B    = 6'b000101;

    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01010;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_LD2   = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    localparam logic [1:0] NPC_HOLD = 2'd0;
    localparam logic [1:0] NPC_INC  = 2'd1;
    localparam logic [1:0] NPC_BR   = 2'd2;
    localparam logic [1:0] NPC_B    = 2'd3;

    typedef struct packed {
        logic [4:0] sa;
        logic [4:0] sb;
        logic [4:0] da;
        logic [4:0] fs;
        logic       k_sel;
        logic       c0;
        logic       en_alu;
        logic       en_b;
        logic       en_addr;
        logic       w;
        logic       cs;
        logic       we;
        logic       oe;
        logic       pc_sel;
    } ctrl_t;

    // K lives outside ctrl_t so its width can follow DW.
    localparam ctrl_t CTRL_IDLE = '{sa: 5'd31, sb: 5'd31, da: 5'd31, fs: 5'd0,
                                    k_sel: 1'b0, c0: 1'b0, en_alu: 1'b0, en_b: 1'b0,
                                    en_addr: 1'b0, w: 1'b0, cs: 1'b0, we: 1'b0,
                                    oe: 1'b0, pc_sel: 1'b0};

endpackage

// File: rtl/ram_datapath_ctrl_decode.sv
// Combinational decode: FSM state + IR -> datapath control word, constant,
// next state and next-PC source.
module ctrl_decode
    import ram_datapath_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic [1:0]    i_state,
    input  logic [31:0]   i_ir,
    input  logic          i_run,
    output ctrl_t         o_ctrl,
    output logic [DW-1:0] o_k,
    output logic [DW-1:0] o_boff,
    output logic [1:0]    o_next_state,
    output logic [1:0]    o_npc_sel
);

    logic [10:0]   w_op11;
    logic [9:0]    w_op10;
    logic [4:0]    w_rd;
    logic [4:0]    w_rn;
    logic [4:0]    w_rm;
    logic [DW-1:0] w_imm12;
    logic [DW-1:0] w_dt;
    ctrl_t         w_ld_ctrl;

    assign w_op11  = i_ir[31:21];
    assign w_op10  = i_ir[31:22];
    assign w_rd    = i_ir[4:0];
    assign w_rn    = i_ir[9:5];
    assign w_rm    = i_ir[20:16];
    assign w_imm12 = {{(DW-12){1'b0}}, i_ir[21:10]};
    assign w_dt    = {{(DW-9){i_ir[20]}}, i_ir[20:12]};
    assign o_boff  = {{(DW-28){i_ir[25]}}, i_ir[25:0], 2'b00};

    // Shared by both LDUR cycles; only W differs between EXEC and LD2.
    always_comb begin
        w_ld_ctrl         = CTRL_IDLE;
        w_ld_ctrl.sa      = w_rn;
        w_ld_ctrl.da      = w_rd;
        w_ld_ctrl.k_sel   = 1'b1;
        w_ld_ctrl.fs      = FS_ADD;
        w_ld_ctrl.en_addr = 1'b1;
        w_ld_ctrl.cs      = 1'b1;
        w_ld_ctrl.oe      = 1'b1;
    end

    always_comb begin
        o_ctrl       = CTRL_IDLE;
        o_k          = '0;
        o_next_state = i_state;
        o_npc_sel    = NPC_HOLD;
        case (i_state)
            ST_FETCH: begin
                if (i_run) o_next_state = ST_EXEC;
            end
            ST_EXEC: begin
                o_next_state = ST_FETCH;
                o_npc_sel    = NPC_INC;
                if (w_op11 == OP_ADD || w_op11 == OP_SUB) begin
                    o_ctrl.sa     = w_rn;
                    o_ctrl.sb     = w_rm;
                    o_ctrl.da     = w_rd;
                    o_ctrl.fs     = (w_op11 == OP_SUB) ? FS_SUB : FS_ADD;
                    o_ctrl.c0     = (w_op11 == OP_SUB);
                    o_ctrl.en_alu = 1'b1;
                    o_ctrl.w      = 1'b1;
                end else if (w_op10 == OP_ADDI || w_op10 == OP_SUBI) begin
                    o_ctrl.sa     = w_rn;
                    o_ctrl.da     = w_rd;
                    o_k           = w_imm12;
                    o_ctrl.k_sel  = 1'b1;
                    o_ctrl.fs     = (w_op10 == OP_SUBI) ? FS_SUB : FS_ADD;
                    o_ctrl.c0     = (w_op10 == OP_SUBI);
                    o_ctrl.en_alu = 1'b1;
                    o_ctrl.w      = 1'b1;
                end else if (w_op11 == OP_STUR) begin
                    o_ctrl.sa      = w_rn;
                    o_ctrl.sb      = w_rd;
                    o_k            = w_dt;
                    o_ctrl.k_sel   = 1'b1;
                    o_ctrl.fs      = FS_ADD;
                    o_ctrl.en_addr = 1'b1;
                    o_ctrl.en_b    = 1'b1;
                    o_ctrl.cs      = 1'b1;
                    o_ctrl.we      = 1'b1;
                end else if (w_op11 == OP_LDUR) begin
                    o_ctrl       = w_ld_ctrl;
                    o_k          = w_dt;
                    o_next_state = ST_LD2;
                    o_npc_sel    = NPC_HOLD;
                end else if (w_op11 == OP_BR) begin
                    o_ctrl.sa     = w_rn;
                    o_ctrl.pc_sel = 1'b1;
                    o_npc_sel     = NPC_BR;
                end else if (i_ir[31:26] == OP_B) begin
                    o_npc_sel = NPC_B;
                end else begin
                    o_next_state = ST_HALT;
                    o_npc_sel    = NPC_HOLD;
                end
            end
            ST_LD2: begin
                o_ctrl       = w_ld_ctrl;
                o_ctrl.w     = 1'b1;
                o_k          = w_dt;
                o_next_state = ST_FETCH;
                o_npc_sel    = NPC_INC;
            end
            default: o_next_state = ST_HALT;
        endcase
    end

endmodule

// File: rtl/ram_datapath_ctrl.sv
// Multi-cycle LEGv8-subset control unit: holds PC, IR and FSM state and drives
// the ram_datapath control word through ctrl_decode.
module ram_datapath_ctrl
    import ram_datapath_pkg::*;
#(
    parameter int            DW       = 64,
    parameter logic [DW-1:0] PC_RESET = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic [31:0]   instr,
    input  logic [DW-1:0] pc_in,
    output logic [DW-1:0] pc,
    output logic          halted,
    output logic [4:0]    SA,
    output logic [4:0]    SB,
    output logic [4:0]    DA,
    output logic [4:0]    FS,
    output logic [DW-1:0] K,
    output logic          K_SEL,
    output logic          C0,
    output logic          EN_ALU,
    output logic          EN_B,
    output logic          EN_ADDR,
    output logic          W,
    output logic          CS,
    output logic          WE,
    output logic          OE,
    output logic          PC_SEL
);

    logic [DW-1:0] r_pc;
    logic [31:0]   r_ir;
    logic [1:0]    r_state;

    ctrl_t         w_ctrl;
    logic [DW-1:0] w_k;
    logic [DW-1:0] w_boff;
    logic [1:0]    w_next_state;
    logic [1:0]    w_npc_sel;

    ctrl_decode #(.DW(DW)) u_decode (
        .i_state      (r_state),
        .i_ir         (r_ir),
        .i_run        (run),
        .o_ctrl       (w_ctrl),
        .o_k          (w_k),
        .o_boff       (w_boff),
        .o_next_state (w_next_state),
        .o_npc_sel    (w_npc_sel)
    );

    // Controls are decoded from r_state, so an async reset idles them at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc    <= PC_RESET;
            r_ir    <= '0;
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_FETCH && run) r_ir <= instr;
            case (w_npc_sel)
                NPC_INC: r_pc <= r_pc + {{(DW-3){1'b0}}, 3'd4};
                NPC_BR:  r_pc <= pc_in;
                NPC_B:   r_pc <= r_pc + w_boff;
                default: r_pc <= r_pc;
            endcase
        end
    end

    assign pc      = r_pc;
    assign halted  = (r_state == ST_HALT);
    assign SA      = w_ctrl.sa;
    assign SB      = w_ctrl.sb;
    assign DA      = w_ctrl.da;
    assign FS      = w_ctrl.fs;
    assign K       = w_k;
    assign K_SEL   = w_ctrl.k_sel;
    assign C0      = w_ctrl.c0;
    assign EN_ALU  = w_ctrl.en_alu;
    assign EN_B    = w_ctrl.en_b;
    assign EN_ADDR = w_ctrl.en_addr;
    assign W       = w_ctrl.w;
    assign CS      = w_ctrl.cs;
    assign WE      = w_ctrl.we;
    assign OE      = w_ctrl.oe;
    assign PC_SEL  = w_ctrl.pc_sel;

endmodule

// File: tb/tb_ram_datapath_ctrl.sv
// Directed bench for ram_datapath_ctrl: expected per-cycle control words and
// PC are queued with each instruction and popped as the DUT steps.
module tb_ram_datapath_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [31:0] instr;
    logic [63:0] pc_in;
    logic [63:0] pc;
    logic        halted;
    logic [4:0]  SA, SB, DA, FS;
    logic [63:0] K;
    logic        K_SEL, C0, EN_ALU, EN_B, EN_ADDR, W, CS, WE, OE, PC_SEL;

    always #5 clk = ~clk;

    ram_datapath_ctrl #(.DW(64), .PC_RESET(64'h0)) dut (
        .clk(clk), .rst(rst), .run(run), .instr(instr), .pc_in(pc_in),
        .pc(pc), .halted(halted), .SA(SA), .SB(SB), .DA(DA), .FS(FS), .K(K),
        .K_SEL(K_SEL), .C0(C0), .EN_ALU(EN_ALU), .EN_B(EN_B), .EN_ADDR(EN_ADDR),
        .W(W), .CS(CS), .WE(WE), .OE(OE), .PC_SEL(PC_SEL)
    );

    typedef struct packed {
        logic [4:0]  sa, sb, da, fs;
        logic [63:0] k;
        logic [9:0]  flg;  // K_SEL C0 EN_ALU EN_B EN_ADDR W CS WE OE PC_SEL
        logic        halted;
        logic [63:0] pc;
    } obs_t;

    typedef struct {
        string tag;
        obs_t  v;
    } exp_t;

    obs_t w_obs;
    assign w_obs = {SA, SB, DA, FS, K, K_SEL, C0, EN_ALU, EN_B, EN_ADDR, W, CS, WE, OE,
                    PC_SEL, halted, pc};

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    function automatic obs_t mk(logic [4:0] sa, logic [4:0] sb, logic [4:0] da,
                                logic [4:0] fs, logic [63:0] k, logic [9:0] f,
                                logic h, logic [63:0] p);
        return {sa, sb, da, fs, k, f, h, p};
    endfunction

    function automatic obs_t idle(logic [63:0] p, logic h);
        return mk(5'd31, 5'd31, 5'd31, 5'd0, 64'd0, 10'd0, h, p);
    endfunction

    task automatic push(input string tag, input obs_t v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        q.push_back(e);
    endtask

    task automatic chk_now();
        exp_t e;
        n_vec++;
        if (q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed=%h expected=<entry>", w_obs);
        end else begin
            e = q.pop_front();
            assert (w_obs === e.v) else begin
                n_fail++;
                $error("FAIL %s: observed=%h expected=%h", e.tag, w_obs, e.v);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk_now();
    endtask

    localparam logic [9:0] F_ADDI = 10'b1010010000;
    localparam logic [9:0] F_SUBI = 10'b1110010000;
    localparam logic [9:0] F_ADD  = 10'b0010010000;
    localparam logic [9:0] F_SUB  = 10'b0110010000;
    localparam logic [9:0] F_STUR = 10'b1001101100;
    localparam logic [9:0] F_LD1  = 10'b1000101010;
    localparam logic [9:0] F_LD2  = 10'b1000111010;
    localparam logic [9:0] F_BR   = 10'b0000000001;

    initial begin
        rst   = 1'b0;
        run   = 1'b0;
        instr = 32'h0;
        pc_in = 64'h0;
        #2;
        push("reset_idle", idle(64'h0, 1'b0));
        chk_now();

        // Reset held across edges with run=1: nothing must move.
        run   = 1'b1;
        instr = 32'h91003FE0;
        push("reset_hold", idle(64'h0, 1'b0));
        tick();
        @(negedge clk);
        rst = 1'b1;

        // ADDI X0,X31,#15
        push("addi_exec", mk(5'd31, 5'd31, 5'd0, 5'b01000, 64'hF, F_ADDI, 1'b0, 64'h0));
        push("addi_next", idle(64'h4, 1'b0));
        tick(); tick();

        // LDUR X6,[X0,#0]; run drops during LD2 and must not stall it
        instr = 32'hF8400006;
        push("ldur_exec", mk(5'd0, 5'd31, 5'd6, 5'b01000, 64'h0, F_LD1, 1'b0, 64'h4));
        push("ldur_ld2",  mk(5'd0, 5'd31, 5'd6, 5'b01000, 64'h0, F_LD2, 1'b0, 64'h4));
        push("ldur_next", idle(64'h8, 1'b0));
        tick();
        run = 1'b0;
        tick(); tick();
        run = 1'b1;

        // STUR X2,[X0,#8]
        instr = 32'hF8008002;
        push("stur_exec", mk(5'd0, 5'd2, 5'd31, 5'b01000, 64'h8, F_STUR, 1'b0, 64'h8));
        push("stur_next", idle(64'hC, 1'b0));
        tick(); tick();

        // SUBI X5,X5,#1
        instr = 32'hD10004A5;
        push("subi_exec", mk(5'd5, 5'd31, 5'd5, 5'b01010, 64'h1, F_SUBI, 1'b0, 64'hC));
        push("subi_next", idle(64'h10, 1'b0));
        tick(); tick();

        // B -1 at pc=0x10
        instr = 32'h17FFFFFF;
        push("b_exec", idle(64'h10, 1'b0));
        push("b_next", idle(64'hC, 1'b0));
        tick(); tick();

        // SUB X7,X8,X9
        instr = 32'hCB090107;
        push("sub_exec", mk(5'd8, 5'd9, 5'd7, 5'b01010, 64'h0, F_SUB, 1'b0, 64'hC));
        push("sub_next", idle(64'h10, 1'b0));
        tick(); tick();

        // run=0 with an illegal word on the bus: must stay in FETCH, IR untouched
        run   = 1'b0;
        instr = 32'h0;
        for (int i = 0; i < 3; i++) push("run0_hold", idle(64'h10, 1'b0));
        tick(); tick(); tick();

        // ADD X1,X2,X3
        run   = 1'b1;
        instr = 32'h8B030041;
        push("add_exec", mk(5'd2, 5'd3, 5'd1, 5'b01000, 64'h0, F_ADD, 1'b0, 64'h10));
        push("add_next", idle(64'h14, 1'b0));
        tick(); tick();

        // BR X6
        instr = 32'hD61F00C0;
        pc_in = 64'h0123_4567_89AB_CDEF;
        push("br_exec", mk(5'd6, 5'd31, 5'd31, 5'd0, 64'h0, F_BR, 1'b0, 64'h14));
        push("br_next", idle(64'h0123_4567_89AB_CDEF, 1'b0));
        tick(); tick();

        // LDUR again, reset asserted mid-LD2
        instr = 32'hF8400006;
        push("ldur2_exec", mk(5'd0, 5'd31, 5'd6, 5'b01000, 64'h0, F_LD1, 1'b0,
                              64'h0123_4567_89AB_CDEF));
        push("ldur2_ld2",  mk(5'd0, 5'd31, 5'd6, 5'b01000, 64'h0, F_LD2, 1'b0,
                              64'h0123_4567_89AB_CDEF));
        tick(); tick();
        #1;
        rst = 1'b0;
        #1;
        push("rst_mid_ld2", idle(64'h0, 1'b0));
        chk_now();
        @(negedge clk);
        rst = 1'b1;

        // Illegal opcode 0 -> HALT, absorbing
        instr = 32'h0;
        push("ill_exec", idle(64'h0, 1'b0));
        push("halt",     idle(64'h0, 1'b1));
        tick(); tick();
        instr = 32'h91003FE0;
        push("halt_hold1", idle(64'h0, 1'b1));
        push("halt_hold2", idle(64'h0, 1'b1));
        tick(); tick();

        if (q.size() != 0) begin
            n_vec++;
            n_fail++;
            $error("FAIL scoreboard_leftover: observed=%0d expected=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_datapath_ctrl.md
Name: ram_datapath_ctrl

Overview:
Multi-cycle control unit directly upstream of ram_datapath. It fetches a 32-bit LEGv8-subset instruction from an instruction ROM and holds the program counter. It decodes the instruction and drives the datapath control word (SA/SB/DA/FS/K/K_SEL/EN_*/W/C0/CS/WE/OE/PC_SEL) that the datapath bench currently drives by hand. It consumes the datapath's PC_in for register-indirect branches.

Parameters:
PC_RESET, 64'h0, PC value loaded on reset
DW, 64, datapath and PC width

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
run  in  1  when 0, FSM holds in FETCH and does not latch the instruction
instr  in  32  instruction ROM data for address pc (combinational ROM)
pc_in  in  DW  datapath PC_in (register A output), used by BR
pc  out  DW  current PC, byte address, to instruction ROM
halted  out  1  1 in HALT state
SA, SB, DA  out  5 each  register selects
FS  out  5  ALU function select
K  out  DW  constant to datapath
K_SEL, C0, EN_ALU, EN_B, EN_ADDR, W, CS, WE, OE, PC_SEL  out  1 each  datapath/RAM controls

Behaviour:
- Reset (rst=0, async): pc=PC_RESET, IR=0, state=FETCH, halted=0. All control outputs take the idle word: SA=SB=DA=31, FS=0, K=0, all 1-bit controls 0.
- States: FETCH, EXEC, LD2, HALT. The control word is a combinational function of state and IR. It is the idle word in FETCH and HALT.
- FETCH: if run=1, IR<=instr and go to EXEC. Otherwise hold.
- Fields: Rd/Rt=IR[4:0], Rn=IR[9:5], Rm=IR[20:16]. imm12=IR[21:10] is zero-extended. DT=IR[20:12] is sign-extended. imm26=IR[25:0] is sign-extended and shifted left by 2.
- ADD (IR[31:21]=10001011000): SA=Rn, SB=Rm, DA=Rd, K_SEL=0, FS=01000, C0=0, EN_ALU=1, W=1.
- SUB (11001011000): as ADD, but FS=01010, C0=1.
- ADDI (IR[31:22]=1001000100): SA=Rn, DA=Rd, K=imm12, K_SEL=1, FS=01000, EN_ALU=1, W=1.
- SUBI (1101000100): as ADDI, but FS=01010, C0=1.
- STUR (11111000000): SA=Rn, SB=Rt, K=DT, K_SEL=1, FS=01000, EN_ADDR=1, EN_B=1, CS=1, WE=1, W=0. Takes one EXEC cycle.
- LDUR (11111000010): two cycles, with an identical word in both except W.
  - Both cycles: SA=Rn, DA=Rt, K=DT, K_SEL=1, FS=01000, EN_ADDR=1, CS=1, OE=1.
  - EXEC: W=0, next state LD2.
  - LD2: W=1, next state FETCH.
- BR (11010110000): SA=Rn, PC_SEL=1. At the end of EXEC, pc<=pc_in.
- B (IR[31:26]=000101): idle word. At the end of EXEC, pc<=pc+imm26 (64-bit wrap).
- PC update for all other legal instructions: pc<=pc+4 at the last execute cycle (EXEC, or LD2 for LDUR). Wraps modulo 2^64.
- Any other opcode: idle word in EXEC, pc unchanged, next state HALT.
- HALT: absorbing. Only a reset exits it.
- Latency: 2 cycles per instruction; 3 for LDUR.
- Reset mid-LDUR: W, CS and OE drop immediately (asynchronously). No register write occurs.
- The run input is sampled only in FETCH. Deasserting it mid-instruction does not stall EXEC or LD2.
- Unused fields (SB for immediates, DA for STUR and BR) are driven to 31, never X.

Decomposition:
- Shared package ram_datapath_pkg holds:
  - opcode constants: OP_ADD, OP_SUB, OP_ADDI, OP_SUBI, OP_LDUR, OP_STUR, OP_BR, OP_B
  - FS_ADD=01000, FS_SUB=01010
  - state encoding
  - the idle control-word constant
- One natural sub-module: ctrl_decode, a combinational IR+state -> control word + next-PC-select. The top keeps the FSM, IR and PC registers.

Test Plan:
- ADDI X0,X31,#15 (instr=32'h91003FE0, run=1) -> cycle 2: SA=31, DA=0, K=64'hF, K_SEL=1, FS=01000, EN_ALU=1, W=1; after it, pc=4.
- LDUR X6,[X0,#0] (32'hF8400006) -> EXEC: CS=1, OE=1, EN_ADDR=1, W=0, DA=6. LD2: same word with W=1. pc advances by 4 only after LD2.
- STUR X2,[X0,#8] (32'hF8008002) -> one cycle with SA=0, SB=2, K=8, CS=1, WE=1, EN_B=1, W=0, OE=0.
- BR X6 (32'hD61F00C0) with pc_in=64'h0123_4567_89AB_CDEF -> SA=6, PC_SEL=1; next pc equals pc_in.
- B -1 (32'h17FFFFFF) at pc=64'h10 -> next pc=64'h0C.
- Illegal opcode 32'h0 -> HALT, halted=1, idle word held, pc frozen.
- rst low during LD2 -> controls go idle in the same cycle, pc=PC_RESET.
- run=0 -> held in FETCH, no change to IR.
